// File: rtl/ram_port_master.sv
// Command-driven master owning the port of a single-port 8x16 RAM.
// Optional write readback verification: define READBACK_CHECK_EN.
module ram_port_master #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf,
  output logic              err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_SUM  = 2'b11;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

`ifdef READBACK_CHECK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_FILL,
    S_SUM, S_VFY, S_RESP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_FILL,
    S_SUM, S_RESP
  } state_t;
`endif

  state_t state_q, state_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_ovf_q,   rsp_ovf_d;
  logic              wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  // words still to process after the current one
  logic [ADDR_W-1:0] cnt_q,       cnt_d;
  logic [DATA_W-1:0] acc_q,       acc_d;
  logic              ovf_q,       ovf_d;
  logic [DATA_W:0]   sum;

`ifdef READBACK_CHECK_EN
  logic              err_q,       err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;

  assign sum = {1'b0, acc_q} + {1'b0, rd_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
`ifdef READBACK_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
`ifdef READBACK_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
`ifdef READBACK_CHECK_EN
    err_d       = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          unique case (cmd_op)
            OP_RD: begin
              rd_addr_d = cmd_addr;
              state_d   = S_RD;
            end
            OP_WR: begin
              wr_en_d   = 1'b1;
              wr_addr_d = cmd_addr;
              wr_data_d = cmd_data;
              cnt_d     = '0;
              state_d   = S_WR;
            end
            OP_FILL: begin
              wr_en_d   = 1'b1;
              wr_addr_d = cmd_addr;
              wr_data_d = cmd_data;
              // len 0 wraps to DEPTH-1 remaining
              cnt_d     = cmd_len - ONE;
              state_d   = S_FILL;
            end
            OP_SUM: begin
              rd_addr_d = cmd_addr;
              cnt_d     = cmd_len - ONE;
              acc_d     = '0;
              ovf_d     = 1'b0;
              state_d   = S_SUM;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_RD: begin
        rsp_data_d  = rd_data;
        rsp_ovf_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end

      S_WR, S_FILL: begin
`ifdef READBACK_CHECK_EN
        rd_addr_d = wr_addr_q;
        state_d   = S_VFY;
`else
        if (cnt_q == '0) begin
          rsp_data_d  = '0;
          rsp_ovf_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + ONE;
          cnt_d     = cnt_q - ONE;
        end
`endif
      end

`ifdef READBACK_CHECK_EN
      S_VFY: begin
        if (rd_data != wr_data_q)
          err_d = 1'b1;
        if (cnt_q == '0) begin
          rsp_data_d  = '0;
          rsp_ovf_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + ONE;
          cnt_d     = cnt_q - ONE;
          state_d   = S_FILL;
        end
      end
`endif

      S_SUM: begin
        acc_d = sum[DATA_W-1:0];
        ovf_d = ovf_q | sum[DATA_W];
        if (cnt_q == '0) begin
          rsp_data_d  = sum[DATA_W-1:0];
          rsp_ovf_d   = ovf_q | sum[DATA_W];
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          rd_addr_d = rd_addr_q + ONE;
          cnt_d     = cnt_q - ONE;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master with a behavioural 8x16 RAM.
// The RAM model can force read bit0 to 0 to provoke readback errors.
module tb_ram_port_master;

`ifdef READBACK_CHECK_EN
  localparam int VF = 1;
`else
  localparam int VF = 0;
`endif

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] FL = 2'b10;
  localparam logic [1:0] SM = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_addr = 3'd0;
  logic [15:0] cmd_data = 16'h0;
  logic [2:0]  cmd_len = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_ovf;
  logic        err;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;

  logic [15:0] mem [8];
  logic        stuck = 1'b0;
  logic        clr = 1'b0;
  logic        ld = 1'b1;
  int          wcnt;
  logic [7:0]  wmask;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  int n;

  always #5 clk = ~clk;

  ram_port_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .err(err), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  assign rd_data = mem[rd_addr] & ~{15'h0, stuck};

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 8; i++)
        mem[i] <= 16'h1000 + 16'(i);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (clr) begin
      wcnt  <= 0;
      wmask <= 8'h00;
    end else if (wr_en) begin
      wcnt  <= wcnt + 1;
      wmask[wr_addr] <= 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [2:0] a,
                       input logic [15:0] d,
                       input logic [2:0] l);
    int k;
    k = 0;
    @(negedge clk);
    cmd_op = op; cmd_addr = a;
    cmd_data = d; cmd_len = l;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int l);
    l = 0;
    while (!rsp_valid && l < 40) begin
      @(negedge clk);
      l++;
    end
    if (l >= 40) chk("rsp_timeout", 0, 1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    ld = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_ovf", rsp_ovf, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    rst = 1'b0;
    clear_log();

    // 1: write then read back
    issue(WR, 3'd3, 16'hBEEF, 3'd0);
    wait_rsp(lat);
    chk("wr_latency", lat, 2 + VF);
    chk("wr_rsp_data", rsp_data, 0);
    ack();
    chk("wr_count", wcnt, 1);
    chk("wr_mem3", mem[3], 16'hBEEF);
    issue(RD, 3'd3, 16'h0, 3'd0);
    wait_rsp(lat);
    chk("rd_latency", lat, 2);
    chk("rd_data3", rsp_data, 16'hBEEF);
    chk("rd_ovf", rsp_ovf, 0);
    ack();

    // 2: fill with wrap 6,7,0,1
    clear_log();
    issue(FL, 3'd6, 16'h1234, 3'd4);
    wait_rsp(lat);
    chk("fill4_latency", lat, 4 * (1 + VF) + 1);
    ack();
    chk("fill4_count", wcnt, 4);
    chk("fill4_mask", wmask, 8'hC3);
    issue(RD, 3'd5, 16'h0, 3'd0);
    wait_rsp(lat);
    chk("rd5_prior", rsp_data, 16'h1005);
    ack();
    issue(RD, 3'd0, 16'h0, 3'd0);
    wait_rsp(lat);
    chk("rd0_fill", rsp_data, 16'h1234);
    ack();

    // 3: full fill and sums
    clear_log();
    issue(FL, 3'd0, 16'h4000, 3'd0);
    wait_rsp(lat);
    chk("fill8_latency", lat, 8 * (1 + VF) + 1);
    ack();
    chk("fill8_mask", wmask, 8'hFF);
    issue(SM, 3'd0, 16'h0, 3'd0);
    wait_rsp(lat);
    chk("sum8_latency", lat, 9);
    chk("sum8_data", rsp_data, 16'h0000);
    chk("sum8_ovf", rsp_ovf, 1);
    ack();
    issue(SM, 3'd0, 16'h0, 3'd3);
    wait_rsp(lat);
    chk("sum3_data", rsp_data, 16'hC000);
    chk("sum3_ovf", rsp_ovf, 0);
    ack();
    issue(SM, 3'd7, 16'h0, 3'd2);
    wait_rsp(lat);
    chk("sum_wrap_data", rsp_data, 16'h8000);
    chk("sum_wrap_ovf", rsp_ovf, 0);
    ack();

    // 4: response backpressure, pending command held off
    clear_log();
    issue(RD, 3'd2, 16'h0, 3'd0);
    wait_rsp(lat);
    chk("bp_rd_data", rsp_data, 16'h4000);
    cmd_op = WR; cmd_addr = 3'd5;
    cmd_data = 16'h5555; cmd_len = 3'd0;
    cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 16'h4000);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    chk("bp_no_write", wcnt, 0);
    ack();
    @(negedge clk);
    chk("bp_ready_after", cmd_ready, 1);
    chk("bp_valid_after", rsp_valid, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp(lat);
    ack();
    chk("bp_wr_count", wcnt, 1);
    chk("bp_mem5", mem[5], 16'h5555);

    // 5: reset during a full fill after three writes
    clear_log();
    issue(FL, 3'd0, 16'h7777, 3'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (wcnt < 3 && n < 40);
    rst = 1'b1;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_count", wcnt, 3);
    chk("abort_mask", wmask, 8'h07);
    chk("abort_mem2", mem[2], 16'h7777);
    chk("abort_mem3", mem[3], 16'h4000);
    chk("abort_no_rsp", rsp_valid, 0);
    chk("abort_ready", cmd_ready, 1);

    // 6: readback check with bit0 stuck at 0
    chk("err_clear", err, 0);
    stuck = 1'b1;
    issue(WR, 3'd4, 16'h0001, 3'd0);
    wait_rsp(lat);
    ack();
    stuck = 1'b0;
    chk("err_set", err, VF);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, VF);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
